// File: rtl/ipv4_checksum_arbiter.sv
// rtl/ipv4_checksum_arbiter.sv - round-robin sharing of one pipelined IPv4 checksum generator among N requesters
module ipv4_checksum_arbiter #(
  parameter int N           = 4,
  parameter int CHK_LATENCY = 2,
  parameter int HDR_W       = 136
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         s_req_valid,
  output logic [N-1:0]         s_req_ready,
  input  logic [N*HDR_W-1:0]   s_req_hdr,
  output logic                 m_chk_req,
  output logic [HDR_W-1:0]     m_chk_hdr,
  input  logic                 m_chk_valid,
  input  logic [15:0]          m_chk_sum,
  output logic [N-1:0]         rsp_valid,
  output logic [15:0]          rsp_chksum,
  output logic                 err_unexpected
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CHK_LATENCY + 1) + 1;

  if (HDR_W != 136) begin : g_bad_hdr_w
    $error("ipv4_checksum_arbiter: HDR_W must be 136");
  end
  if (N < 1 || N > 16) begin : g_bad_n
    $error("ipv4_checksum_arbiter: N must be 1..16");
  end
  if (CHK_LATENCY < 1) begin : g_bad_lat
    $error("ipv4_checksum_arbiter: CHK_LATENCY must be at least 1");
  end

  typedef enum logic {ST_BLANK, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     blank_cnt_q, blank_cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              m_chk_req_q, m_chk_req_d;
  logic [HDR_W-1:0]  m_chk_hdr_q, m_chk_hdr_d;
  logic [IW-1:0]     iss_idx_q, iss_idx_d;
  logic [CHK_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [IW-1:0]     pipe_idx_q [CHK_LATENCY];
  logic [IW-1:0]     pipe_idx_d [CHK_LATENCY];
  logic [N-1:0]      rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_chksum_q, rsp_chksum_d;
  logic              err_q, err_d;

  logic [N-1:0]      ready;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     cand;
  logic              transfer;
  logic              tail_vld;
  logic [IW-1:0]     tail_idx;

  // The generator has no reset, so results are ignored until its pipeline has flushed.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    if (state_q == ST_BLANK) begin
      if (blank_cnt_q == CW'(CHK_LATENCY)) begin
        state_d = ST_RUN;
      end else begin
        blank_cnt_d = blank_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    ready    = '0;
    gnt_idx  = '0;
    cand     = '0;
    transfer = 1'b0;
    if (state_q == ST_RUN) begin
      for (int k = 1; k <= N; k++) begin
        cand = IW'((int'(ptr_q) + k) % N);
        if (!transfer && s_req_valid[cand]) begin
          transfer     = 1'b1;
          ready[cand]  = 1'b1;
          gnt_idx      = cand;
        end
      end
    end
  end

  assign tail_vld = pipe_vld_q[CHK_LATENCY-1];
  assign tail_idx = pipe_idx_q[CHK_LATENCY-1];

  always_comb begin
    ptr_d        = transfer ? gnt_idx : ptr_q;
    m_chk_req_d  = transfer;
    m_chk_hdr_d  = transfer ? s_req_hdr[int'(gnt_idx)*HDR_W +: HDR_W] : m_chk_hdr_q;
    iss_idx_d    = gnt_idx;
    pipe_vld_d    = '0;
    pipe_vld_d[0] = m_chk_req_q;
    pipe_idx_d[0] = iss_idx_q;
    for (int k = 1; k < CHK_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
    rsp_valid_d  = '0;
    rsp_chksum_d = rsp_chksum_q;
    err_d        = err_q;
    if (state_q == ST_RUN) begin
      if (m_chk_valid && tail_vld) begin
        rsp_valid_d[tail_idx] = 1'b1;
        rsp_chksum_d          = m_chk_sum;
      end
      // Either an orphan result or a lost one means the generator and ID pipe disagree.
      if (m_chk_valid != tail_vld) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      blank_cnt_q  <= '0;
      ptr_q        <= IW'(N - 1);
      m_chk_req_q  <= 1'b0;
      m_chk_hdr_q  <= '0;
      iss_idx_q    <= '0;
      pipe_vld_q   <= '0;
      for (int k = 0; k < CHK_LATENCY; k++) begin
        pipe_idx_q[k] <= '0;
      end
      rsp_valid_q  <= '0;
      rsp_chksum_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      ptr_q        <= ptr_d;
      m_chk_req_q  <= m_chk_req_d;
      m_chk_hdr_q  <= m_chk_hdr_d;
      iss_idx_q    <= iss_idx_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int k = 0; k < CHK_LATENCY; k++) begin
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
      rsp_valid_q  <= rsp_valid_d;
      rsp_chksum_q <= rsp_chksum_d;
      err_q        <= err_d;
    end
  end

  assign s_req_ready    = ready;
  assign m_chk_req      = m_chk_req_q;
  assign m_chk_hdr      = m_chk_hdr_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_chksum     = rsp_chksum_q;
  assign err_unexpected = err_q;

endmodule
